// File: rtl/tiny_rv_lsu_pkg.sv
// Shared types and lane/extend helpers for the pipelined RV32 load/store unit.
package tiny_rv_lsu_pkg;

  localparam logic [2:0] F3_BYTE    = 3'b000;
  localparam logic [2:0] F3_HALF    = 3'b001;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BYTE_US = 3'b100;
  localparam logic [2:0] F3_HALF_US = 3'b101;

  // Access size is funct3[1:0]; the reserved size 2'b11 is handled as a word.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic [1:0] {
    CAUSE_NONE       = 2'd0,
    CAUSE_MISALIGNED = 2'd1,
    CAUSE_BUS_ERR    = 2'd2
  } lsu_cause_t;

  // Per-request bookkeeping kept while the bus access is in flight.
  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
  } lsu_meta_t;

  localparam int unsigned META_W = $bits(lsu_meta_t);

  // Byte offset actually used for lane steering; low bits below the access size are ignored.
  function automatic logic [1:0] eff_off(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: return a;
      SZ_HALF: return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return a[0];
      default: return (a != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] a);
    logic [1:0] off;
    off = eff_off(size, a);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [1:0] a,
                                              input logic [31:0] wdata);
    logic [1:0] off;
    off = eff_off(size, a);
    return wdata << {off, 3'b000};
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {eff_off(f3[1:0], a), 3'b000};
    case (f3)
      F3_BYTE:    return {{24{sh[7]}}, sh[7:0]};
      F3_BYTE_US: return {24'h0, sh[7:0]};
      F3_HALF:    return {{16{sh[15]}}, sh[15:0]};
      F3_HALF_US: return {16'h0, sh[15:0]};
      default:    return sh;
    endcase
  endfunction

endpackage

// File: rtl/tiny_rv_lsu_fifo.sv
// Synchronous metadata FIFO with flush; head entry is visible combinationally.
module tiny_rv_lsu_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy next-state; flush wins over push/pop.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = ptr_inc(wr_q);
      if (do_pop)  rd_d = ptr_inc(rd_q);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer/occupancy registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents are meaningless while empty so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/tiny_rv_lsu_pipe.sv
// Pipelined RV32 load/store unit driving a pipelined Wishbone B4 master, in-order responses.
module tiny_rv_lsu_pipe
  import tiny_rv_lsu_pkg::*;
#(
  parameter int unsigned AW            = 30,
  parameter int unsigned MAX_OUTST     = 4,
  parameter bit          MISALIGN_TRAP = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_we,
  input  logic [2:0]    i_req_funct3,
  input  logic [31:0]   i_req_addr,
  input  logic [31:0]   i_req_wdata,
  output logic          o_rsp_valid,
  output logic [31:0]   o_rsp_data,
  output logic          o_rsp_err,
  output logic [1:0]    o_rsp_cause,
  output logic [31:0]   o_rsp_badaddr,
  output logic          o_busy,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [31:0]   o_wb_data,
  output logic [3:0]    o_wb_sel,
  input  logic          i_wb_ack,
  input  logic          i_wb_stall,
  input  logic          i_wb_err,
  input  logic [31:0]   i_wb_data
);

  localparam int unsigned CW = $clog2(MAX_OUTST + 1);

  logic [CW-1:0] count_q, count_d;
  logic          stb_q, stb_d, cyc_q, cyc_d, busy_q, busy_d;
  logic          we_q, we_d, drain_q, drain_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   data_q, data_d;
  logic          rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0]   rsp_data_q, rsp_data_d, rsp_badaddr_q, rsp_badaddr_d;
  lsu_cause_t    rsp_cause_q, rsp_cause_d;

  logic          misal_c, ready_c, accept_c, push_c, beat_c, ack_c, err_c;
  logic          fifo_full, fifo_empty;
  lsu_meta_t     head_c, push_meta_c;

  // Accept/handshake decode. Misaligned traps only go when the bus is idle so they stay in order.
  always_comb begin
    misal_c  = MISALIGN_TRAP && is_misaligned(i_req_funct3[1:0], i_req_addr[1:0]);
    ready_c  = !drain_q && (!stb_q || !i_wb_stall) && (count_q < CW'(MAX_OUTST)) && !fifo_full &&
               (!misal_c || ((count_q == '0) && !stb_q));
    accept_c = i_req_valid && ready_c;
    push_c   = accept_c && !misal_c;
    beat_c   = stb_q && !i_wb_stall;
    // Responses with nothing outstanding are stray and ignored; err dominates a simultaneous ack.
    err_c    = i_wb_err && (count_q != '0) && !fifo_empty;
    ack_c    = i_wb_ack && !i_wb_err && (count_q != '0) && !fifo_empty;
    push_meta_c = '{we: i_req_we, funct3: i_req_funct3, addr: i_req_addr};
  end

  assign o_req_ready = ready_c;

  tiny_rv_lsu_fifo #(
    .WIDTH (META_W),
    .DEPTH (MAX_OUTST)
  ) u_meta_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .flush_i (err_c),
    .push_i  (push_c),
    .pop_i   (ack_c || err_c),
    .wdata_i (push_meta_c),
    .rdata_o (head_c),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Bus master and response next-state.
  always_comb begin
    stb_d         = stb_q;
    we_d          = we_q;
    addr_d        = addr_q;
    sel_d         = sel_q;
    data_d        = data_q;
    drain_d       = 1'b0;
    count_d       = count_q + CW'(beat_c) - CW'(ack_c || err_c);
    rsp_valid_d   = 1'b0;
    rsp_data_d    = 32'h0;
    rsp_err_d     = 1'b0;
    rsp_cause_d   = CAUSE_NONE;
    rsp_badaddr_d = 32'h0;

    if (beat_c) stb_d = 1'b0;

    if (push_c) begin
      stb_d  = 1'b1;
      we_d   = i_req_we;
      addr_d = AW'(i_req_addr[31:2]);
      sel_d  = lane_sel(i_req_funct3[1:0], i_req_addr[1:0]);
      data_d = store_lanes(i_req_funct3[1:0], i_req_addr[1:0], i_req_wdata);
    end

    if (accept_c && misal_c) begin
      rsp_valid_d   = 1'b1;
      rsp_err_d     = 1'b1;
      rsp_cause_d   = CAUSE_MISALIGNED;
      rsp_badaddr_d = i_req_addr;
    end

    if (ack_c) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = head_c.we ? 32'h0 : load_extend(head_c.funct3, head_c.addr[1:0], i_wb_data);
    end

    // A bus error aborts the whole cycle; younger in-flight accesses are dropped.
    if (err_c) begin
      rsp_valid_d   = 1'b1;
      rsp_err_d     = 1'b1;
      rsp_cause_d   = CAUSE_BUS_ERR;
      rsp_badaddr_d = head_c.addr;
      stb_d         = 1'b0;
      count_d       = '0;
      drain_d       = 1'b1;
    end

    cyc_d  = stb_d || (count_d != '0);
    busy_d = cyc_d;
  end

  // State and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q       <= '0;
      stb_q         <= 1'b0;
      cyc_q         <= 1'b0;
      busy_q        <= 1'b0;
      we_q          <= 1'b0;
      drain_q       <= 1'b0;
      addr_q        <= '0;
      sel_q         <= '0;
      data_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      rsp_cause_q   <= CAUSE_NONE;
      rsp_badaddr_q <= '0;
    end else begin
      count_q       <= count_d;
      stb_q         <= stb_d;
      cyc_q         <= cyc_d;
      busy_q        <= busy_d;
      we_q          <= we_d;
      drain_q       <= drain_d;
      addr_q        <= addr_d;
      sel_q         <= sel_d;
      data_q        <= data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
      rsp_cause_q   <= rsp_cause_d;
      rsp_badaddr_q <= rsp_badaddr_d;
    end
  end

  assign o_wb_cyc      = cyc_q;
  assign o_wb_stb      = stb_q;
  assign o_wb_we       = we_q;
  assign o_wb_addr     = addr_q;
  assign o_wb_sel      = sel_q;
  assign o_wb_data     = data_q;
  assign o_busy        = busy_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_data    = rsp_data_q;
  assign o_rsp_err     = rsp_err_q;
  assign o_rsp_cause   = rsp_cause_q;
  assign o_rsp_badaddr = rsp_badaddr_q;

endmodule

// File: tb/tb_tiny_rv_lsu_pipe.sv
// Scoreboard bench for tiny_rv_lsu_pipe with a pipelined Wishbone slave model.
`timescale 1ns/1ps
module tb_tiny_rv_lsu_pipe;
  import tiny_rv_lsu_pkg::*;

  localparam int K_OK = 0, K_MIS = 1, K_ERR = 2, K_DROP = 3;

  logic        i_clk = 1'b0, i_reset = 1'b1;
  logic        i_req_valid = 1'b0, i_req_we = 1'b0;
  logic [2:0]  i_req_funct3 = 3'b0;
  logic [31:0] i_req_addr = 32'h0, i_req_wdata = 32'h0;
  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_busy;
  logic [31:0] o_rsp_data, o_rsp_badaddr;
  logic [1:0]  o_rsp_cause;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [29:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack = 1'b0, i_wb_stall = 1'b0, i_wb_err = 1'b0;
  logic [31:0] i_wb_data = 32'h0;

  tiny_rv_lsu_pipe #(.AW(30), .MAX_OUTST(4), .MISALIGN_TRAP(1'b1)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
    .i_req_funct3(i_req_funct3), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .o_rsp_cause(o_rsp_cause), .o_rsp_badaddr(o_rsp_badaddr), .o_busy(o_busy),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel), .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall),
    .i_wb_err(i_wb_err), .i_wb_data(i_wb_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [31:0] data; logic err; logic [1:0] cause; logic [31:0] bad; bit bus; } rsp_t;
  typedef struct { logic we; logic [29:0] addr; logic [3:0] sel; logic [31:0] wdata;
                   logic [31:0] rdata; int berr; int lat; } beat_t;
  typedef struct { int due; logic [31:0] rdata; int berr; } pend_t;

  rsp_t  exp_rsp[$];
  beat_t exp_beat[$];
  pend_t pend[$];
  int    ack_cyc[$];
  int    checks = 0, errors = 0, cyc_n = 0, rsp_seen = 0;
  bit    stall_rand = 1'b0, stray_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  always @(posedge i_clk) cyc_n <= cyc_n + 1;

  // Wishbone slave: records beats, answers in order after each beat's latency, aborts when cyc drops.
  always @(negedge i_clk) begin
    beat_t b;
    pend_t p;
    i_wb_ack  = 1'b0;
    i_wb_err  = 1'b0;
    i_wb_data = 32'h0;
    if (i_reset || !o_wb_cyc) pend.delete();
    i_wb_stall = stall_rand && ($urandom_range(0, 2) == 0);
    if (!i_reset && o_wb_stb && !i_wb_stall) begin
      if (exp_beat.size() == 0) begin
        checks++; errors++;
        $display("FAIL wb_beat: unexpected beat at word 0x%08h", 32'(o_wb_addr));
      end else begin
        b = exp_beat.pop_front();
        chk("wb_addr", 32'(o_wb_addr), 32'(b.addr));
        chk("wb_sel", 32'(o_wb_sel), 32'(b.sel));
        chk("wb_we", 32'(o_wb_we), 32'(b.we));
        if (b.we) chk("wb_wdata", o_wb_data, b.wdata);
        p.due = cyc_n + b.lat; p.rdata = b.rdata; p.berr = b.berr;
        pend.push_back(p);
      end
    end
    if (pend.size() > 0 && pend[0].due <= cyc_n) begin
      p = pend.pop_front();
      i_wb_ack  = (p.berr != 1);
      i_wb_err  = (p.berr != 0);
      i_wb_data = p.rdata;
      ack_cyc.push_back(cyc_n);
    end else if (stray_ack) begin
      i_wb_ack  = 1'b1;
      i_wb_data = 32'h5555AAAA;
    end
  end

  // Response monitor: pops the scoreboard whenever a response is presented.
  always @(negedge i_clk) begin
    rsp_t e;
    if (!i_reset && o_rsp_valid) begin
      rsp_seen++;
      if (exp_rsp.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected: data 0x%08h err %0d cause %0d", o_rsp_data, o_rsp_err, o_rsp_cause);
      end else begin
        e = exp_rsp.pop_front();
        chk("rsp_err", 32'(o_rsp_err), 32'(e.err));
        chk("rsp_cause", 32'(o_rsp_cause), 32'(e.cause));
        if (!e.err) chk("rsp_data", o_rsp_data, e.data);
        else        chk("rsp_badaddr", o_rsp_badaddr, e.bad);
        if (e.bus) begin
          if (ack_cyc.size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp_latency: response with no preceding ack");
          end else chk("rsp_latency", 32'(cyc_n), 32'(ack_cyc.pop_front() + 1));
        end
        if (e.err && e.cause == 2'd2) begin
          chk("buserr_cyc_drop", 32'(o_wb_cyc), 32'h0);
          chk("buserr_drain_ready", 32'(o_req_ready), 32'h0);
        end
      end
    end
  end

  // Offer one request, wait (bounded) for acceptance, and record the expected beat and response.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] sel, input logic [31:0] wbdata,
                       input logic [31:0] rdata, input int berr, input int lat, input int kind,
                       input logic [31:0] exp_data, output int waits);
    beat_t b;
    rsp_t  e;
    waits = 0;
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_we = we; i_req_funct3 = f3; i_req_addr = addr; i_req_wdata = wdata;
    #2;
    while (!o_req_ready && waits < 200) begin
      @(negedge i_clk); #2; waits++;
    end
    if (!o_req_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout: addr 0x%08h never accepted", addr);
      i_req_valid = 1'b0;
      return;
    end
    if (kind != K_MIS) begin
      b.we = we; b.addr = addr[31:2]; b.sel = sel; b.wdata = wbdata;
      b.rdata = rdata; b.berr = berr; b.lat = lat;
      exp_beat.push_back(b);
    end
    if (kind != K_DROP) begin
      e.data  = exp_data;
      e.bus   = (kind != K_MIS);
      e.err   = (kind == K_MIS || kind == K_ERR);
      e.cause = (kind == K_MIS) ? 2'd1 : (kind == K_ERR) ? 2'd2 : 2'd0;
      e.bad   = addr;
      exp_rsp.push_back(e);
    end
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge i_clk);
    while ((exp_rsp.size() != 0 || o_wb_cyc) && n < 300) begin
      @(negedge i_clk); n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s: still busy, %0d responses outstanding", name, exp_rsp.size());
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, w5, r0;
    repeat (3) @(negedge i_clk);
    chk("reset_cyc", 32'(o_wb_cyc), 32'h0);
    chk("reset_stb", 32'(o_wb_stb), 32'h0);
    chk("reset_busy", 32'(o_busy), 32'h0);
    chk("reset_rsp_valid", 32'(o_rsp_valid), 32'h0);
    chk("reset_sel", 32'(o_wb_sel), 32'h0);
    i_reset = 1'b0;

    // Basic word load, byte/half loads with sign and zero extension.
    issue(0, F3_WORD, 32'h100, 0, 4'b1111, 0, 32'hDEADBEEF, 0, 2, K_OK, 32'hDEADBEEF, w);
    wait_idle("lw_idle");
    issue(0, F3_BYTE,    32'h103, 0, 4'b1000, 0, 32'h80123456, 0, 1, K_OK, 32'hFFFFFF80, w);
    issue(0, F3_BYTE_US, 32'h103, 0, 4'b1000, 0, 32'h80123456, 0, 1, K_OK, 32'h00000080, w);
    issue(0, F3_BYTE,    32'h101, 0, 4'b0010, 0, 32'h00007F00, 0, 2, K_OK, 32'h0000007F, w);
    issue(0, F3_HALF,    32'h102, 0, 4'b1100, 0, 32'hBEEF1234, 0, 1, K_OK, 32'hFFFFBEEF, w);
    issue(0, F3_HALF_US, 32'h102, 0, 4'b1100, 0, 32'hBEEF1234, 0, 1, K_OK, 32'h0000BEEF, w);
    wait_idle("loads_idle");

    // Stores: lane steering and zero response data.
    issue(1, F3_HALF, 32'h202, 32'h00001234, 4'b1100, 32'h12340000, 32'hFFFFFFFF, 0, 1, K_OK, 32'h0, w);
    issue(1, F3_BYTE, 32'h201, 32'hCAFE00AB, 4'b0010, 32'hFE00AB00, 32'hFFFFFFFF, 0, 2, K_OK, 32'h0, w);
    issue(1, F3_WORD, 32'h204, 32'hA5A50F0F, 4'b1111, 32'hA5A50F0F, 32'h0, 0, 1, K_OK, 32'h0, w);
    wait_idle("stores_idle");

    // Four in flight back-to-back; the fifth waits for the first ack.
    issue(0, F3_WORD, 32'h010, 0, 4'hF, 0, 32'h11111111, 0, 3, K_OK, 32'h11111111, w);
    chk("b2b_wait1", 32'(w), 32'h0);
    issue(0, F3_WORD, 32'h014, 0, 4'hF, 0, 32'h22222222, 0, 3, K_OK, 32'h22222222, w);
    chk("b2b_wait2", 32'(w), 32'h0);
    issue(0, F3_WORD, 32'h018, 0, 4'hF, 0, 32'h33333333, 0, 3, K_OK, 32'h33333333, w);
    chk("b2b_wait3", 32'(w), 32'h0);
    issue(0, F3_WORD, 32'h01C, 0, 4'hF, 0, 32'h44444444, 0, 3, K_OK, 32'h44444444, w);
    chk("b2b_wait4", 32'(w), 32'h0);
    issue(0, F3_WORD, 32'h020, 0, 4'hF, 0, 32'h55555555, 0, 1, K_OK, 32'h55555555, w5);
    chk("fifth_held", 32'(w5 > 0), 32'h1);
    wait_idle("b2b_idle");

    // Misaligned traps never start a bus cycle.
    issue(0, F3_WORD, 32'h101, 0, 4'h0, 0, 0, 0, 0, K_MIS, 0, w);
    chk("mis_no_cyc", 32'(o_wb_cyc), 32'h0);
    issue(0, F3_HALF, 32'h103, 0, 4'h0, 0, 0, 0, 0, K_MIS, 0, w);
    issue(1, F3_WORD, 32'h202, 32'h1, 4'h0, 0, 0, 0, 0, K_MIS, 0, w);
    wait_idle("mis_idle");

    // A misaligned request behind an outstanding load waits and keeps order.
    issue(0, F3_WORD, 32'h300, 0, 4'hF, 0, 32'h01020304, 0, 6, K_OK, 32'h01020304, w);
    issue(0, F3_WORD, 32'h102, 0, 4'h0, 0, 0, 0, 0, K_MIS, 0, w);
    chk("mis_waits_outstanding", 32'(w > 0), 32'h1);
    wait_idle("mis_order_idle");

    // Bus error on the middle of three loads; the third is discarded.
    issue(0, F3_WORD, 32'h400, 0, 4'hF, 0, 32'hAAAA0001, 0, 2, K_OK, 32'hAAAA0001, w);
    issue(0, F3_WORD, 32'h404, 0, 4'hF, 0, 32'h0, 1, 2, K_ERR, 0, w);
    issue(0, F3_WORD, 32'h408, 0, 4'hF, 0, 32'hAAAA0003, 0, 2, K_DROP, 0, w);
    wait_idle("buserr_idle");
    issue(0, F3_WORD, 32'h40C, 0, 4'hF, 0, 32'h0BADF00D, 0, 1, K_OK, 32'h0BADF00D, w);
    // ack and err together count as a bus error.
    issue(0, F3_HALF_US, 32'h502, 0, 4'b1100, 0, 32'h12345678, 2, 1, K_ERR, 0, w);
    wait_idle("ackerr_idle");

    // A stray ack with nothing outstanding produces no response.
    r0 = rsp_seen;
    @(posedge i_clk); #1; stray_ack = 1'b1;
    @(posedge i_clk); #1; stray_ack = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("stray_ack_no_rsp", 32'(rsp_seen), 32'(r0));
    chk("stray_ack_not_busy", 32'(o_busy), 32'h0);

    // Random stall burst.
    stall_rand = 1'b1;
    for (int i = 0; i < 6; i++)
      issue(0, F3_WORD, 32'h600 + 32'(4 * i), 0, 4'hF, 0, 32'h10000000 + 32'(i), 0, 1 + (i % 3),
            K_OK, 32'h10000000 + 32'(i), w);
    issue(1, F3_BYTE, 32'h603, 32'h00000077, 4'b1000, 32'h77000000, 0, 0, 1, K_OK, 32'h0, w);
    issue(0, F3_HALF, 32'h600, 0, 4'b0011, 0, 32'h00008001, 0, 2, K_OK, 32'hFFFF8001, w);
    wait_idle("stall_idle");

    // Reset in the middle of a stalled burst.
    for (int i = 0; i < 3; i++)
      issue(0, F3_WORD, 32'h680 + 32'(4 * i), 0, 4'hF, 0, 32'h0, 0, 20, K_DROP, 0, w);
    stall_rand = 1'b0;
    @(negedge i_clk); i_reset = 1'b1;
    @(posedge i_clk); #1;
    @(negedge i_clk); #1;
    exp_beat.delete();
    ack_cyc.delete();
    chk("midreset_cyc", 32'(o_wb_cyc), 32'h0);
    chk("midreset_stb", 32'(o_wb_stb), 32'h0);
    chk("midreset_busy", 32'(o_busy), 32'h0);
    chk("midreset_rsp_valid", 32'(o_rsp_valid), 32'h0);
    i_reset = 1'b0;
    issue(0, F3_WORD, 32'h700, 0, 4'hF, 0, 32'hC0FFEE00, 0, 1, K_OK, 32'hC0FFEE00, w);
    wait_idle("final_idle");
    chk("scoreboard_empty", 32'(exp_rsp.size()), 32'h0);
    chk("beats_consumed", 32'(exp_beat.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
